// File: rtl/filter_sweep_ctrl.sv
// filter_sweep_ctrl: sweeps the A/B inputs of the glitch filter through the
// four Gray-ordered combinations. It counts low samples of the synchronized
// X during each combination, then samples the synchronized OutResult and
// reports one verdict.
//
// Handshake: START is a level request. It is taken in IDLE, or in the single
// DONE cycle, and is ignored while BUSY=1 (no queuing). DONE is a one-cycle
// "verdict valid" strobe. PASS, GLITCH_CNT and FAIL_STEP are valid from that
// cycle and hold until the next sweep starts.
module filter_sweep_ctrl #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             X,
    input  logic             OutResult,
    output logic             A,
    output logic             B,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [CNT_W-1:0] GLITCH_CNT,
    output logic [1:0]       FAIL_STEP
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] WIN_FIRST = HW'(2);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_STEP  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       step_q, step_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             chk_q, chk_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       fstep_q, fstep_d;
    logic             pass_q, pass_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             x_meta_q, xs_q;
    logic             or_meta_q, ors_q;
    logic             start_sweep;

    // Two-flop synchronizers for the asynchronous X and OutResult inputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            x_meta_q  <= 1'b1;
            xs_q      <= 1'b1;
            or_meta_q <= 1'b1;
            ors_q     <= 1'b1;
        end else begin
            x_meta_q  <= X;
            xs_q      <= x_meta_q;
            or_meta_q <= OutResult;
            ors_q     <= or_meta_q;
        end
    end

    // Next-state logic for the sweep FSM, counters, verdict and A/B drive.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        hold_d      = hold_q;
        chk_d       = chk_q;
        cnt_d       = cnt_q;
        fstep_d     = fstep_q;
        pass_d      = pass_q;
        start_sweep = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START) start_sweep = 1'b1;
            end
            S_STEP: begin
                // The first two hold cycles cover synchronizer latency after A/B move.
                if (hold_q >= WIN_FIRST && !xs_q) begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == '0) fstep_d = step_q;
                end
                if (hold_q == HOLD_LAST) begin
                    hold_d = '0;
                    if (step_q == 2'd3) begin
                        state_d = S_CHECK;
                        chk_d   = 1'b0;
                    end else begin
                        step_d = step_q + 2'd1;
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            S_CHECK: begin
                if (chk_q) begin
                    state_d = S_DONE;
                    pass_d  = (cnt_q == '0) && ors_q;
                end else begin
                    chk_d = 1'b1;
                end
            end
            S_DONE: begin
                if (START) start_sweep = 1'b1;
                else       state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (start_sweep) begin
            state_d = S_STEP;
            step_d  = 2'd0;
            hold_d  = '0;
            cnt_d   = '0;
            fstep_d = 2'd0;
            pass_d  = 1'b0;
        end

        // Gray order 00,01,11,10; CHECK keeps step 3, so it stays at (1,0).
        a_d = 1'b0;
        b_d = 1'b0;
        if (state_d == S_STEP || state_d == S_CHECK) begin
            a_d = step_d[1];
            b_d = step_d[1] ^ step_d[0];
        end
    end

    // State and result registers; reset aborts any sweep without a DONE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            step_q  <= 2'd0;
            hold_q  <= '0;
            chk_q   <= 1'b0;
            cnt_q   <= '0;
            fstep_q <= 2'd0;
            pass_q  <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            hold_q  <= hold_d;
            chk_q   <= chk_d;
            cnt_q   <= cnt_d;
            fstep_q <= fstep_d;
            pass_q  <= pass_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign A          = a_q;
    assign B          = b_q;
    assign BUSY       = (state_q == S_STEP) || (state_q == S_CHECK);
    assign DONE       = (state_q == S_DONE);
    assign PASS       = pass_q;
    assign GLITCH_CNT = cnt_q;
    assign FAIL_STEP  = fstep_q;

endmodule

// File: tb/tb_filter_sweep_ctrl.sv
// Bench for filter_sweep_ctrl: one default instance (CNT_W=8) and one
// narrow-counter instance (CNT_W=3) share all stimulus. The driver pushes the
// expected verdict of each sweep, and a monitor pops it when DONE appears.
module tb_filter_sweep_ctrl;

    localparam int H  = 4;
    localparam int NJ = 4 * H + 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic x = 1'b1;
    logic out_result = 1'b1;

    logic       a8, b8, busy8, done8, pass8;
    logic [7:0] cnt8;
    logic [1:0] fs8;
    logic       a3, b3, busy3, done3, pass3;
    logic [2:0] cnt3;
    logic [1:0] fs3;

    filter_sweep_ctrl #(.HOLD_CYCLES(H), .CNT_W(8)) dut (
        .CLK(clk), .RST(rst), .START(start), .X(x), .OutResult(out_result),
        .A(a8), .B(b8), .BUSY(busy8), .DONE(done8), .PASS(pass8),
        .GLITCH_CNT(cnt8), .FAIL_STEP(fs8)
    );

    filter_sweep_ctrl #(.HOLD_CYCLES(H), .CNT_W(3)) dut_sat (
        .CLK(clk), .RST(rst), .START(start), .X(x), .OutResult(out_result),
        .A(a3), .B(b3), .BUSY(busy3), .DONE(done3), .PASS(pass3),
        .GLITCH_CNT(cnt3), .FAIL_STEP(fs3)
    );

    // Clock generation.
    always #5 clk = ~clk;

    typedef struct {
        int   done_cyc;
        logic ps;
        int   c8;
        int   c3;
        int   fs;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    // Gray-ordered A/B patterns, step 0..3.
    logic [3:0] pat_a = 4'b1100;
    logic [3:0] pat_b = 4'b0110;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model. xp[j] is the X level presented before the j-th edge of
    // a sweep (j=0 is the edge that takes START). Window sample k=s*H+h sees
    // X from two edges earlier through the synchronizer, i.e. xp[k-1].
    task automatic model(input logic [NJ-1:0] xp, input logic orv, output exp_t e);
        int n;
        n = 0;
        e.fs = 0;
        for (int k = 0; k < 4 * H; k++) begin
            if ((k % H) >= 2 && xp[k-1] == 1'b0) begin
                if (n == 0) e.fs = k / H;
                n++;
            end
        end
        e.c8 = (n > 255) ? 255 : n;
        e.c3 = (n > 7) ? 7 : n;
        e.ps = (n == 0) && orv;
        e.done_cyc = 0;
    endtask

    // One sweep; mode 1 keeps START high until the DONE cycle. The call ends
    // just before the DONE cycle, so a following call chains a new sweep.
    task automatic run_sweep(input logic [NJ-1:0] xp, input logic orv, input int mode);
        exp_t e;
        int c;
        model(xp, orv, e);
        for (int j = 0; j < NJ; j++) begin
            @(negedge clk);
            c = j - 1;
            if (j == 0) begin
                e.done_cyc = cyc + 1 + 4 * H + 2;
                exp_q.push_back(e);
                last_exp = e;
            end
            if (c < 0) begin
                chk("idle_busy", int'(busy8), 0);
                chk("idle_ab", int'({a8, b8}), 0);
            end else if (c < 4 * H) begin
                chk("step_ab", int'({a8, b8}), int'({pat_a[c/H], pat_b[c/H]}));
                chk("step_ab_sat", int'({a3, b3}), int'({pat_a[c/H], pat_b[c/H]}));
                chk("step_busy", int'(busy8), 1);
                if (c == 0) begin
                    chk("clear_cnt", int'(cnt8), 0);
                    chk("clear_cnt_sat", int'(cnt3), 0);
                    chk("clear_pass", int'(pass8), 0);
                    chk("clear_fs", int'(fs8), 0);
                end
            end else begin
                chk("check_ab", int'({a8, b8}), 2);
                chk("check_busy", int'(busy8), 1);
            end
            x          = xp[j];
            out_result = orv;
            start      = (j == 0) || (mode == 1);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 1'b0;
            x     = 1'b1;
        end
        chk("hold_pass", int'(pass8), int'(last_exp.ps));
        chk("hold_cnt", int'(cnt8), last_exp.c8);
        chk("hold_busy", int'(busy8), 0);
    endtask

    // Starts a sweep with X stuck low and resets it during step 1.
    task automatic run_abort();
        for (int j = 0; j < H + 3; j++) begin
            @(negedge clk);
            start = (j == 0);
            x     = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ab", int'({a8, b8}), 0);
        chk("abort_busy", int'(busy8), 0);
        chk("abort_done", int'(done8), 0);
        chk("abort_cnt", int'(cnt8), 0);
        chk("abort_fs", int'(fs8), 0);
        rst = 1'b0;
        x   = 1'b1;
        last_exp = '{done_cyc: 0, ps: 1'b0, c8: 0, c3: 0, fs: 0};
    endtask

    // Monitor: on every DONE pulse, pop and compare the expected verdict.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (done8 || done3) begin
                chk("done_agree", int'(done3), int'(done8));
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_latency", cyc, e.done_cyc);
                    chk("pass", int'(pass8), int'(e.ps));
                    chk("pass_sat", int'(pass3), int'(e.ps));
                    chk("glitch_cnt", int'(cnt8), e.c8);
                    chk("glitch_cnt_sat", int'(cnt3), e.c3);
                    chk("fail_step", int'(fs8), e.fs);
                    chk("fail_step_sat", int'(fs3), e.fs);
                    chk("done_busy", int'(busy8), 0);
                    chk("done_ab", int'({a8, b8}), 0);
                end
            end
        end
    end

    // Stimulus: reset, directed sweeps, then randomized sweeps.
    initial begin
        logic [NJ-1:0] xp;
        logic orv;
        int sel;
        last_exp = '{done_cyc: 0, ps: 1'b0, c8: 0, c3: 0, fs: 0};

        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ab", int'({a8, b8}), 0);
        chk("rst_busy", int'(busy8), 0);
        chk("rst_done", int'(done8), 0);
        chk("rst_pass", int'(pass8), 0);
        chk("rst_cnt", int'(cnt8), 0);
        chk("rst_fs", int'(fs8), 0);
        rst = 1'b0;
        idle(2);

        // Clean sweep.
        run_sweep({NJ{1'b1}}, 1'b1, 0);
        idle(3);

        // One low Xs sample inside step 2's window.
        xp = {NJ{1'b1}};
        xp[2*H+1] = 1'b0;
        run_sweep(xp, 1'b1, 0);
        idle(3);

        // Xs low only during hold cycle 0 of step 1: outside every window.
        xp = {NJ{1'b1}};
        xp[H-1] = 1'b0;
        run_sweep(xp, 1'b1, 0);
        idle(3);

        // Filter failure only.
        run_sweep({NJ{1'b1}}, 1'b0, 0);
        idle(3);

        // X stuck low: 8 window samples, narrow counter saturates at 7.
        run_sweep({NJ{1'b0}}, 1'b1, 0);
        idle(3);

        // Reset mid-sweep, then a clean sweep.
        run_abort();
        idle(2);
        run_sweep({NJ{1'b1}}, 1'b1, 0);
        idle(3);

        // START held through the sweep.
        run_sweep({NJ{1'b1}}, 1'b1, 1);
        idle(3);

        // Glitchy sweep chained into a clean one from the DONE cycle.
        xp = {NJ{1'b1}};
        xp[4] = 1'b0;
        run_sweep(xp, 1'b1, 0);
        run_sweep({NJ{1'b1}}, 1'b1, 0);
        idle(3);

        // Randomized sweeps.
        for (int n = 0; n < 24; n++) begin
            sel = $urandom_range(0, 3);
            xp  = {NJ{1'b1}};
            if (sel == 1) begin
                for (int j = 0; j < NJ; j++) xp[j] = ($urandom_range(0, 5) != 0);
            end else if (sel == 2) begin
                xp = {NJ{1'b0}};
            end else if (sel == 3) begin
                xp[$urandom_range(0, NJ - 1)] = 1'b0;
            end
            orv = ($urandom_range(0, 3) != 0);
            run_sweep(xp, orv, $urandom_range(0, 1));
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 4));
        end
        idle(30);
        chk("pending_exp", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
